// File: rtl/st_mem_pkg.sv
// Shared constants, state type and lane-compare helper for the stream-to-RAM writer.
package st_mem_pkg;

    localparam int ADDR_W         = 10;
    localparam int LEN_W          = 13;
    localparam int BYTES_PER_WORD = 4;
    localparam int MAX_LEN        = 4096;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FILL  = 3'd1,
        ST_WRITE = 3'd2,
        ST_RDBK  = 3'd3,
        ST_CMP   = 3'd4,
        ST_DONE  = 3'd5
    } st_state_e;

    // True when any enabled byte lane of a differs from the same lane of b.
    function automatic logic lanes_differ(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [3:0]  be);
        logic d;
        d = 1'b0;
        for (int i = 0; i < BYTES_PER_WORD; i++) begin
            if (be[i] && (a[i*8 +: 8] != b[i*8 +: 8])) d = 1'b1;
        end
        return d;
    endfunction

endpackage

// File: rtl/st_byte_packer.sv
// Little-endian byte packer: collects up to four bytes into a word with lane enables.
module st_byte_packer
    import st_mem_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clear,
    input  logic        push,
    input  logic        last,
    input  logic [7:0]  data,
    output logic [31:0] word,
    output logic [3:0]  be,
    output logic        word_done
);

    logic [1:0]  byte_idx;
    logic [31:0] word_q;
    logic [3:0]  be_q;

    // Flags the push that completes a word, either by filling lane 3 or by ending the command.
    assign word_done = push && ((byte_idx == 2'(BYTES_PER_WORD - 1)) || last);
    assign word      = word_q;
    assign be        = be_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            byte_idx <= '0;
            word_q   <= '0;
            be_q     <= '0;
        end else if (clear) begin
            byte_idx <= '0;
            word_q   <= '0;
            be_q     <= '0;
        end else if (push) begin
            word_q[{byte_idx, 3'b000} +: 8] <= data;
            be_q[byte_idx]                  <= 1'b1;
            byte_idx                        <= byte_idx + 2'd1;
        end
    end

endmodule

// File: rtl/st_to_mem_writer.sv
// Avalon-ST byte sink to Avalon-MM word writer with incrementing, wrapping word address.
// Optional readback verification is compiled in with `define ST_TO_MEM_VERIFY_EN.
module st_to_mem_writer
    import st_mem_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  length,
    input  logic [7:0]        snk_data,
    input  logic              snk_valid,
    output logic              snk_ready,
    output logic [ADDR_W-1:0] avm_address,
    output logic [3:0]        avm_byteenable,
    output logic              avm_chipselect,
    output logic              avm_write,
    output logic [31:0]       avm_writedata,
    output logic              avm_read,
    input  logic [31:0]       avm_readdata,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [10:0]       words_written,
    output logic [2:0]        state_dbg
);

    localparam logic [2:0] S_IDLE  = 3'(ST_IDLE);
    localparam logic [2:0] S_FILL  = 3'(ST_FILL);
    localparam logic [2:0] S_WRITE = 3'(ST_WRITE);
    localparam logic [2:0] S_DONE  = 3'(ST_DONE);
`ifdef ST_TO_MEM_VERIFY_EN
    localparam logic [2:0] S_RDBK  = 3'(ST_RDBK);
    localparam logic [2:0] S_CMP   = 3'(ST_CMP);
`endif

    logic [2:0]        state, state_nxt;
    logic [ADDR_W-1:0] addr_q;
    logic [LEN_W-1:0]  remain_q;
    logic [LEN_W-1:0]  len_clamped;
    logic [10:0]       words_q;
    logic              start_acc;
    logic              accept;
    logic              word_end;
    logic [31:0]       pk_word;
    logic [3:0]        pk_be;
    logic              pk_word_done;

    assign len_clamped = (length > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : length;
    assign start_acc   = (state == S_IDLE) && start;

    // Stream handshake: a byte transfers on every rising edge where snk_valid and
    // snk_ready are both high; snk_ready never depends on snk_valid. A zero-length
    // command passes through FILL with ready held low so no byte is taken.
    assign snk_ready = (state == S_FILL) && (remain_q != '0);
    assign accept    = snk_valid && snk_ready;

`ifdef ST_TO_MEM_VERIFY_EN
    assign word_end = (state == S_CMP);
`else
    assign word_end = (state == S_WRITE);
`endif

    st_byte_packer u_packer (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     (start_acc || word_end),
        .push      (accept),
        .last      (remain_q == LEN_W'(1)),
        .data      (snk_data),
        .word      (pk_word),
        .be        (pk_be),
        .word_done (pk_word_done)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_FILL;
            S_FILL: begin
                if (remain_q == '0)    state_nxt = S_DONE;
                else if (pk_word_done) state_nxt = S_WRITE;
            end
`ifdef ST_TO_MEM_VERIFY_EN
            S_WRITE: state_nxt = S_RDBK;
            S_RDBK:  state_nxt = S_CMP;
            S_CMP:   state_nxt = (remain_q != '0) ? S_FILL : S_DONE;
`else
            S_WRITE: state_nxt = (remain_q != '0) ? S_FILL : S_DONE;
`endif
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            addr_q   <= '0;
            remain_q <= '0;
            words_q  <= '0;
        end else begin
            state <= state_nxt;
            if (start_acc) begin
                addr_q   <= base_addr;
                remain_q <= len_clamped;
                words_q  <= '0;
            end
            if (accept)            remain_q <= remain_q - LEN_W'(1);
            if (state == S_WRITE)  words_q  <= words_q + 11'd1;
            // Natural overflow gives the wrap from the top word back to 0.
            if (word_end)          addr_q   <= addr_q + ADDR_W'(1);
        end
    end

    always_comb begin
        avm_address    = '0;
        avm_byteenable = '0;
        avm_chipselect = 1'b0;
        avm_write      = 1'b0;
        avm_writedata  = '0;
        avm_read       = 1'b0;
        if (state == S_WRITE) begin
            avm_address    = addr_q;
            avm_byteenable = pk_be;
            avm_chipselect = 1'b1;
            avm_write      = 1'b1;
            avm_writedata  = pk_word;
        end
`ifdef ST_TO_MEM_VERIFY_EN
        if (state == S_RDBK) begin
            avm_address    = addr_q;
            avm_byteenable = pk_be;
            avm_chipselect = 1'b1;
            avm_read       = 1'b1;
        end
`endif
    end

`ifdef ST_TO_MEM_VERIFY_EN
    logic err_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_q <= 1'b0;
        end else if (start_acc) begin
            err_q <= 1'b0;
        end else if ((state == S_CMP) && lanes_differ(avm_readdata, pk_word, pk_be)) begin
            err_q <= 1'b1;
        end
    end

    assign error = err_q;
`else
    logic unused_rdata;
    assign unused_rdata = ^avm_readdata;
    assign error        = 1'b0;
`endif

    assign busy          = (state != S_IDLE);
    assign done          = (state == S_DONE);
    assign words_written = words_q;
    assign state_dbg     = state;

endmodule

// File: tb/tb_st_to_mem_writer.sv
// Directed plus randomized bench for st_to_mem_writer with a word-level reference model,
// a RAM model on the Avalon-MM side and a write scoreboard.
module tb_st_to_mem_writer;

    localparam int W = 46;  // {address[9:0], byteenable[3:0], writedata[31:0]}
`ifdef ST_TO_MEM_VERIFY_EN
    localparam int DONE_LAT = 3;
    localparam int WORD_CYC = 7;
`else
    localparam int DONE_LAT = 1;
    localparam int WORD_CYC = 5;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [9:0]  base_addr;
    logic [12:0] length;
    logic [7:0]  snk_data;
    logic        snk_valid;
    logic        snk_ready;
    logic [9:0]  avm_address;
    logic [3:0]  avm_byteenable;
    logic        avm_chipselect;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic        avm_read;
    logic [31:0] avm_readdata;
    logic        busy;
    logic        done;
    logic        error;
    logic [10:0] words_written;
    logic [2:0]  state_dbg;

    st_to_mem_writer dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (start),
        .base_addr      (base_addr),
        .length         (length),
        .snk_data       (snk_data),
        .snk_valid      (snk_valid),
        .snk_ready      (snk_ready),
        .avm_address    (avm_address),
        .avm_byteenable (avm_byteenable),
        .avm_chipselect (avm_chipselect),
        .avm_write      (avm_write),
        .avm_writedata  (avm_writedata),
        .avm_read       (avm_read),
        .avm_readdata   (avm_readdata),
        .busy           (busy),
        .done           (done),
        .error          (error),
        .words_written  (words_written),
        .state_dbg      (state_dbg)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    logic [W-1:0] exp_q[$];
    int errors = 0;
    int checks = 0;
    int done_cnt = 0;
    int wr_seen = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // ---------------- RAM model ----------------
    logic [31:0] mem [0:1023];
    logic        corrupt_en = 1'b0;
    logic [9:0]  corrupt_addr = '0;

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        avm_readdata = '0;
    end

    always @(posedge clk) begin
        logic [31:0] rd;
        if (avm_chipselect && avm_write) begin
            for (int l = 0; l < 4; l++)
                if (avm_byteenable[l]) mem[avm_address][l*8 +: 8] <= avm_writedata[l*8 +: 8];
        end
        if (avm_chipselect && avm_read) begin
            rd = mem[avm_address];
            if (corrupt_en && (avm_address == corrupt_addr)) rd[23:16] = ~rd[23:16];
            avm_readdata <= rd;
        end
    end

    // ---------------- bus monitor ----------------
    always @(negedge clk) begin
        logic [W-1:0] got;
        logic [W-1:0] want;
        if (done) done_cnt++;
        if (avm_chipselect && avm_write) begin
            wr_seen++;
            got  = {avm_address, avm_byteenable, avm_writedata};
            want = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
            check("sb_write", got, want);
            check("no_read_with_write", avm_read, 1'b0);
        end
        if (!avm_chipselect)
            check("bus_idle_zero", {avm_write, avm_read, avm_address, avm_byteenable, avm_writedata}, 0);
    end

    // ---------------- reference model ----------------
    function automatic void model_cmd(input int base, input int len, input logic [7:0] bytes[$]);
        int n;
        logic [31:0] d;
        logic [3:0]  be;
        n = (len > 4096) ? 4096 : len;
        for (int w = 0; w * 4 < n; w++) begin
            d  = '0;
            be = '0;
            for (int l = 0; l < 4; l++) begin
                if (w * 4 + l < n) begin
                    d[l*8 +: 8] = bytes[w * 4 + l];
                    be[l]       = 1'b1;
                end
            end
            exp_q.push_back({10'((base + w) % 1024), be, d});
        end
    endfunction

    // ---------------- driver tasks ----------------
    task automatic do_start(input logic [9:0] b, input logic [12:0] l);
        @(posedge clk); #1;
        start     = 1'b1;
        base_addr = b;
        length    = l;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // gap: 0 = always valid, 1 = valid every other cycle, 2 = random valid
    task automatic feed(input logic [7:0] bytes[$], input int n, input int gap, output int e);
        int i;
        int guard;
        logic acc;
        i = 0;
        guard = 0;
        e = cyc;
        while (i < n && guard < 20 * n + 100) begin
            snk_valid = (gap == 0) ? 1'b1 : (gap == 1) ? ~snk_valid : 1'($urandom_range(0, 1));
            snk_data  = bytes[i];
            acc       = snk_valid && snk_ready;
            @(posedge clk); #1;
            guard++;
            if (acc) begin
                i++;
                e = cyc;
                if ((i % 4 == 0) || (i == n)) begin
                    check("ready_low_in_write", snk_ready, 1'b0);
                    check("write_after_word", avm_write, 1'b1);
                end
            end
        end
        snk_valid = 1'b0;
        check("feed_complete", i, n);
    endtask

    task automatic run_cmd(input logic [9:0] b, input int len, input int gap,
                           input logic [7:0] bytes[$], input logic glitch, input logic exp_err);
        int n;
        int s;
        int e;
        int exp_done;
        int dc0;
        int guard;
        n   = (len > 4096) ? 4096 : len;
        dc0 = done_cnt;
        model_cmd(b, len, bytes);
        do_start(b, 13'(len));
        s = cyc;
        check("first_ready", snk_ready, (n != 0));
        check("busy_after_start", busy, 1'b1);
        check("error_cleared_on_start", error, 1'b0);
        if (glitch) begin
            start     = 1'b1;
            base_addr = ~b;
            length    = 13'd9;
            @(posedge clk); #1;
            start = 1'b0;
        end
        feed(bytes, n, gap, e);
        exp_done = (n == 0) ? s + 1 : e + DONE_LAT;
        guard = 0;
        while (!done && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        check("done_seen", done, 1'b1);
        check("done_cycle", cyc, exp_done);
        if (gap == 0 && n != 0 && n % 4 == 0 && !glitch)
            check("throughput", cyc - s, WORD_CYC * (n / 4));
        check("busy_with_done", busy, 1'b1);
        check("words_written", words_written, (n + 3) / 4);
        check("error_at_done", error, exp_err);
        @(posedge clk); #1;
        check("done_one_cycle", done, 1'b0);
        check("busy_dropped", busy, 1'b0);
        check("sb_drained", exp_q.size(), 0);
        check("one_done_pulse", done_cnt - dc0, 1);
    endtask

    function automatic void seq_bytes(ref logic [7:0] q[$], input int n, input logic [7:0] first);
        q.delete();
        for (int i = 0; i < n; i++) q.push_back(first + 8'(i));
    endfunction

    function automatic void rand_bytes(ref logic [7:0] q[$], input int n);
        q.delete();
        for (int i = 0; i < n; i++) q.push_back(8'($urandom_range(0, 255)));
    endfunction

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [7:0] q[$];
        int w0;
        int guard;

        reset_n   = 1'b0;
        start     = 1'b0;
        base_addr = '0;
        length    = '0;
        snk_data  = '0;
        snk_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ctrl_outputs",
              {snk_ready, busy, done, error, avm_chipselect, avm_write, avm_read}, 0);
        check("reset_bus_outputs", {avm_address, avm_byteenable, avm_writedata}, 0);
        check("reset_words_written", words_written, 0);
        reset_n = 1'b1;
        @(posedge clk); #1;
        check("idle_after_reset", {busy, snk_ready, done}, 0);

        // Two full words at 0x010
        seq_bytes(q, 8, 8'h01);
        run_cmd(10'h010, 8, 0, q, 1'b0, 1'b0);

        // Wrap from 0x3FF to 0x000 with a two-lane final word
        seq_bytes(q, 6, 8'hAA);
        run_cmd(10'h3FF, 6, 0, q, 1'b0, 1'b0);

        // Zero-length command
        w0 = wr_seen;
        q.delete();
        run_cmd(10'h123, 0, 0, q, 1'b0, 1'b0);
        check("len0_no_writes", wr_seen - w0, 0);

        // Gapped stream plus a start pulse while busy
        w0 = wr_seen;
        seq_bytes(q, 4, 8'h5A);
        run_cmd(10'h080, 4, 1, q, 1'b1, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        check("ignored_start_idle", busy, 1'b0);
        check("gapped_single_write", wr_seen - w0, 1);

        // Reset after two of four bytes
        w0 = wr_seen;
        do_start(10'h200, 13'd4);
        snk_valid = 1'b1;
        snk_data  = 8'h11;
        @(posedge clk); #1;
        snk_data = 8'h22;
        @(posedge clk); #1;
        snk_valid = 1'b0;
        reset_n   = 1'b0;
        #1;
        check("midreset_ctrl_zero",
              {snk_ready, busy, done, error, avm_chipselect, avm_write, avm_read}, 0);
        check("midreset_bus_zero", {avm_address, avm_byteenable, avm_writedata}, 0);
        check("midreset_words_zero", words_written, 0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        guard = 0;
        while (guard < 10) begin
            @(posedge clk); #1;
            guard++;
        end
        check("midreset_no_write", wr_seen - w0, 0);
        check("midreset_stays_idle", busy, 1'b0);
        seq_bytes(q, 5, 8'hC0);
        run_cmd(10'h200, 5, 0, q, 1'b0, 1'b0);

`ifdef ST_TO_MEM_VERIFY_EN
        // Corrupt lane 2 of the second word on readback
        corrupt_addr = 10'h051;
        corrupt_en   = 1'b1;
        seq_bytes(q, 12, 8'h30);
        run_cmd(10'h050, 12, 0, q, 1'b0, 1'b1);
        corrupt_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("error_sticky", error, 1'b1);
`endif

        // Random commands
        for (int k = 0; k < 6; k++) begin
            int len;
            len = $urandom_range(1, 23);
            rand_bytes(q, len);
            run_cmd(10'($urandom_range(0, 1023)), len, $urandom_range(0, 2), q, 1'b0, 1'b0);
        end

        // Oversized length clamps to 4096 bytes (1024 words, full address wrap)
        rand_bytes(q, 4096);
        run_cmd(10'($urandom_range(0, 1023)), 5000, 0, q, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
